frame_sweep_ctrl: RTL and testbench

FRAME_SWEEP_CTRL -- requirements
Module: frame_sweep_ctrl

---
 rtl/frame_sweep_ctrl_if.sv | 32 +++
 rtl/frame_sweep_ctrl.sv | 109 ++++++++++
 tb/tb_frame_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sweep_ctrl_if.sv
// Handshake and status bundle between the frame sweep controller and its
// writer, consumer and RAM.
interface frame_sweep_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              clear;
  logic              load_start;
  logic              loop;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              busy;
  logic              sweep_done;
  logic [7:0]        frame_cnt;

  modport master (
    output clear, load_start, loop, wr_valid, rd_ready,
    input  wr_ready, wr_en, wr_addr, rd_en, rd_addr, rd_valid,
           busy, sweep_done, frame_cnt
  );

  modport slave (
    input  clear, load_start, loop, wr_valid, rd_ready,
    output wr_ready, wr_en, wr_addr, rd_en, rd_addr, rd_valid,
           busy, sweep_done, frame_cnt
  );
endinterface

// File: rtl/frame_sweep_ctrl.sv
// Fill / settle / sweep sequencer for a DEPTH-entry frame buffer with a
// 1-cycle-latency RAM read path and optional sweep replay.
module frame_sweep_ctrl #(
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int SETTLE_CYC = 127
) (
  input  logic               clk,
  input  logic               reset,
  frame_sweep_ctrl_if.slave  bus
);

  localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  typedef enum logic [2:0] {IDLE, FILL, SETTLE, SWEEP, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic              rd_valid_q;
  logic [7:0]        frame_cnt_q;
  logic              wr_en, rd_en, done;

  // clear gates strobes and the done pulse within the same cycle
  always_comb begin
    wr_en     = (state_q == FILL)  && bus.wr_valid && !bus.clear;
    rd_en     = (state_q == SWEEP) && bus.rd_ready && !bus.clear;
    done      = (state_q == DONE)  && !bus.clear;
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    settle_d  = settle_q;
    if (bus.clear) begin
      state_d   = IDLE;
      wr_addr_d = '0;
      rd_addr_d = '0;
      settle_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load_start) begin
            state_d   = FILL;
            wr_addr_d = '0;
          end
        end
        FILL: begin
          if (wr_en) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
              state_d  = SETTLE;
              settle_d = '0;
            end
          end
        end
        SETTLE: begin
          if (settle_q == CNT_W'(SETTLE_CYC)) begin
            state_d   = SWEEP;
            rd_addr_d = '0;
          end else begin
            settle_d = settle_q + CNT_W'(1);
          end
        end
        SWEEP: begin
          if (rd_en) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            if (rd_addr_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
          end
        end
        DONE: begin
          rd_addr_d = '0;
          state_d   = bus.loop ? SWEEP : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      settle_q    <= '0;
      rd_valid_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      settle_q   <= settle_d;
      rd_valid_q <= rd_en;
      if (done) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  always_comb begin
    bus.wr_ready   = (state_q == FILL);
    bus.wr_en      = wr_en;
    bus.wr_addr    = wr_addr_q;
    bus.rd_en      = rd_en;
    bus.rd_addr    = rd_addr_q;
    bus.rd_valid   = rd_valid_q;
    bus.busy       = (state_q != IDLE);
    bus.sweep_done = done;
    bus.frame_cnt  = frame_cnt_q;
  end

endmodule

// File: tb/tb_frame_sweep_ctrl.sv
// Self-checking bench for frame_sweep_ctrl with DEPTH=8, SETTLE_CYC=3.
module tb_frame_sweep_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int SETTLE = 3;

  logic clk;
  logic reset;

  frame_sweep_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();

  frame_sweep_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE_CYC(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard queues of expected write / read addresses
  int unsigned wq[$];
  int unsigned rq[$];
  bit          mon_en = 1'b0;
  bit          prev_rd_en = 1'b0;
  bit          fc_pending = 1'b0;
  logic [7:0]  exp_fc = '0;
  int unsigned done_cnt = 0;
  int unsigned rv_cnt = 0;
  int unsigned wr_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc.wr_en) begin
        wr_cnt++;
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_addr", 32'(ifc.wr_addr), wq.pop_front());
      end
      if (ifc.rd_en) begin
        if (rq.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", 32'(ifc.rd_addr), rq.pop_front());
      end
      chk("rd_valid_lag", 32'(ifc.rd_valid), 32'(prev_rd_en));
      if (fc_pending) begin
        chk("frame_cnt_after_done", 32'(ifc.frame_cnt), 32'(exp_fc));
        fc_pending = 1'b0;
      end
      if (ifc.sweep_done) begin
        done_cnt++;
        exp_fc = exp_fc + 8'd1;
        fc_pending = 1'b1;
      end
      if (ifc.rd_valid) rv_cnt++;
      prev_rd_en = ifc.rd_en;
    end else begin
      prev_rd_en = 1'b0;
    end
  end

  typedef struct {
    string       name;
    bit          wr_toggle;
    bit          rd_stall;
    bit          loop_en;
    int unsigned exp_sweeps;
    int unsigned exp_settle;
  } vec_t;

  vec_t vecs[4];

  task automatic start_fill();
    @(posedge clk); #1;
    ifc.load_start = 1'b1;
    @(posedge clk); #1;
    ifc.load_start = 1'b0;
  endtask

  task automatic do_fill(input bit toggle);
    for (int i = 0; i < 100; i++) begin
      ifc.wr_valid = toggle ? ((i % 2) == 0) : 1'b1;
      @(posedge clk); #1;
      if (wq.size() == 0) break;
    end
    ifc.wr_valid = 1'b0;
    chk("fill_complete", wq.size(), 0);
  endtask

  task automatic measure_settle(input bit poke_load, output int unsigned n);
    n = 0;
    ifc.rd_ready   = 1'b1;
    ifc.load_start = poke_load;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.rd_en) break;
      n++;
      chk("settle_no_wr_ready", 32'(ifc.wr_ready), 0);
      @(posedge clk); #1;
      ifc.load_start = 1'b0;
    end
    ifc.load_start = 1'b0;
  endtask

  initial begin
    int unsigned n, d0, rv0, wr0, k;
    logic [7:0]  fc0;

    ifc.clear = 0; ifc.load_start = 0; ifc.loop = 0;
    ifc.wr_valid = 0; ifc.rd_ready = 0;
    reset = 1'b0;

    vecs[0] = '{name: "basic",     wr_toggle: 0, rd_stall: 0, loop_en: 0, exp_sweeps: 1, exp_settle: 4};
    vecs[1] = '{name: "wr_toggle", wr_toggle: 1, rd_stall: 0, loop_en: 0, exp_sweeps: 1, exp_settle: 4};
    vecs[2] = '{name: "rd_stall",  wr_toggle: 0, rd_stall: 1, loop_en: 0, exp_sweeps: 1, exp_settle: 4};
    vecs[3] = '{name: "loop2",     wr_toggle: 0, rd_stall: 0, loop_en: 1, exp_sweeps: 2, exp_settle: 4};

    #12;
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_wr_ready", 32'(ifc.wr_ready), 0);
    chk("rst_wr_addr", 32'(ifc.wr_addr), 0);
    chk("rst_rd_addr", 32'(ifc.rd_addr), 0);
    chk("rst_rd_valid", 32'(ifc.rd_valid), 0);
    chk("rst_sweep_done", 32'(ifc.sweep_done), 0);
    chk("rst_frame_cnt", 32'(ifc.frame_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt; rv0 = rv_cnt; wr0 = wr_cnt; fc0 = exp_fc;
      for (int a = 0; a < DEPTH; a++) wq.push_back(a);
      for (int s = 0; s < int'(vecs[v].exp_sweeps); s++)
        for (int a = 0; a < DEPTH; a++) rq.push_back(a);
      ifc.loop = vecs[v].loop_en;
      start_fill();
      chk({vecs[v].name, "_busy"}, 32'(ifc.busy), 1);
      chk({vecs[v].name, "_wr_ready"}, 32'(ifc.wr_ready), 1);
      do_fill(vecs[v].wr_toggle);
      chk({vecs[v].name, "_wr_pulses"}, wr_cnt - wr0, DEPTH);
      measure_settle(1'b0, n);
      chk({vecs[v].name, "_settle_len"}, n, vecs[v].exp_settle);
      k = 1;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (done_cnt >= d0 + vecs[v].exp_sweeps) break;
        if (done_cnt > d0) ifc.loop = 1'b0;
        ifc.rd_ready = vecs[v].rd_stall ? ((k % 3) != 2) : 1'b1;
        k++;
      end
      ifc.rd_ready = 1'b0;
      ifc.loop = 1'b0;
      @(negedge clk);
      chk({vecs[v].name, "_sweeps"}, done_cnt - d0, vecs[v].exp_sweeps);
      chk({vecs[v].name, "_rd_valid_cnt"}, rv_cnt - rv0, DEPTH * vecs[v].exp_sweeps);
      chk({vecs[v].name, "_rq_empty"}, rq.size(), 0);
      chk({vecs[v].name, "_idle"}, 32'(ifc.busy), 0);
      chk({vecs[v].name, "_frame_cnt"}, 32'(ifc.frame_cnt), 32'(fc0 + 8'(vecs[v].exp_sweeps)));
    end

    // clear mid-sweep at rd_addr 4, with load_start poked during SETTLE
    d0 = done_cnt; fc0 = exp_fc;
    for (int a = 0; a < DEPTH; a++) wq.push_back(a);
    for (int a = 0; a < 4; a++) rq.push_back(a);
    start_fill();
    do_fill(1'b0);
    measure_settle(1'b1, n);
    chk("settle_len_with_load", n, SETTLE + 1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ifc.rd_addr == 3'd4) break;
    end
    chk("clr_at_addr4", 32'(ifc.rd_addr), 4);
    ifc.clear = 1'b1;
    #1;
    chk("clr_rd_en_gated", 32'(ifc.rd_en), 0);
    chk("clr_no_done", 32'(ifc.sweep_done), 0);
    @(posedge clk); #1;
    ifc.clear = 1'b0;
    chk("clr_idle", 32'(ifc.busy), 0);
    chk("clr_rd_addr", 32'(ifc.rd_addr), 0);
    @(negedge clk);
    chk("clr_rd_valid", 32'(ifc.rd_valid), 0);
    chk("clr_frame_cnt", 32'(ifc.frame_cnt), 32'(fc0));
    chk("clr_done_cnt", done_cnt - d0, 0);
    chk("clr_rq_empty", rq.size(), 0);

    // clear wins over load_start in IDLE
    @(posedge clk); #1;
    ifc.clear = 1'b1; ifc.load_start = 1'b1;
    @(posedge clk); #1;
    ifc.clear = 1'b0; ifc.load_start = 1'b0;
    chk("clr_load_idle", 32'(ifc.busy), 0);
    @(posedge clk); #1;
    chk("clr_load_idle2", 32'(ifc.busy), 0);

    // asynchronous reset between edges during FILL
    for (int a = 0; a < DEPTH; a++) wq.push_back(a);
    start_fill();
    ifc.wr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(ifc.busy), 0);
    chk("arst_wr_addr", 32'(ifc.wr_addr), 0);
    chk("arst_wr_en", 32'(ifc.wr_en), 0);
    chk("arst_wr_ready", 32'(ifc.wr_ready), 0);
    chk("arst_rd_valid", 32'(ifc.rd_valid), 0);
    chk("arst_frame_cnt", 32'(ifc.frame_cnt), 0);
    wq.delete();
    exp_fc = '0;
    fc_pending = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(ifc.busy), 0);
    chk("post_rst_no_wr", 32'(ifc.wr_en), 0);
    ifc.wr_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
